vend_credit_fsm: RTL and testbench
==================================

// Module: vend_credit_fsm
// PURPOSE
//  Parametrised vending controller: accumulates coin credit, vends when credit >= PRICE,
//  returns change one coin per handshake, refunds on cancel or inactivity timeout.
//  Sits between the coin acceptor front-end and the dispense/change actuators.
// PARAMETERS
//  PRICE     15   item price in Rs; must be a multiple of 5 and >= 5 (elaboration check)
//  CREDIT_W  6    credit register width; must satisfy 2**CREDIT_W > PRICE+15 (elab check)
//  TIMEOUT   200  idle cycles in COLLECT before automatic refund; >= 2
// PORTS
//  clk         in   1         single clock, all state on rising edge
//  rst         in   1         synchronous reset, active-high
//  coin_valid  in   1         coin present this cycle
//  coin        in   2         01=Rs5, 10=Rs10, 11=Rs20, 00=illegal
//  cancel      in   1         request refund of current credit
//  chg_ready   in   1         change actuator accepts chg_coin this cycle
//  dispense    out  1         one-cycle pulse: release item
//  coin_reject out  1         one-cycle pulse: sampled coin not credited
//  chg_valid   out  1         change coin offered
//  chg_coin    out  2         01=Rs5, 10=Rs10; 00 when chg_valid=0
//  busy        out  1         1 in any state except IDLE
//  credit      out  CREDIT_W  current credit in Rs
// BEHAVIOUR
//  Reset: state IDLE, credit=0, timeout count=0, all outputs 0. rst overrides everything,
//   incl. mid-change: pending change is discarded (no refund).
//  States: IDLE, COLLECT, VEND, CHANGE. All outputs registered.
//  IDLE: legal coin -> credit=value; go VEND if value>=PRICE else COLLECT. Illegal -> reject.
//  COLLECT: legal coin -> credit+=value, timeout count cleared; credit>=PRICE -> VEND.
//   cancel -> CHANGE (refund whole credit); cancel+coin same cycle: cancel wins, coin rejected.
//   No coin for TIMEOUT consecutive cycles -> CHANGE as if cancel.
//  VEND: dispense=1 for exactly this cycle; credit-=PRICE; remainder 0 -> IDLE else CHANGE.
//  CHANGE: chg_valid=1; chg_coin=10 if credit>=10 else 01 (greedy). On chg_valid&chg_ready
//   credit-=coin value; credit reaching 0 -> IDLE. chg_coin stable while chg_ready=0.
//  coin_valid in VEND/CHANGE or illegal code anywhere -> coin_reject pulse next cycle,
//   credit unchanged. cancel ignored outside COLLECT.
//  Latency: coin reaching PRICE sampled at edge N -> dispense high in cycle N+1;
//   first chg_valid in cycle N+2. Credit visible on `credit` one cycle after sampling.
//  Arithmetic: credit always a multiple of 5, so change is always exact; no saturation needed.
// CONFIGURATION
//  VEND_SALES_CNT_EN defined: adds output sales_cnt[15:0], +1 per dispense pulse,
//   saturates at 16'hFFFF, cleared by rst. Undefined: port and counter absent; all other
//   behaviour identical.
// STRUCTURE
//  Package vend_pkg: state enum, coin code localparams (COIN_5/10/20), function
//   coin_value(code) -> Rs.
//  One sub-module: vend_change_gen (greedy coin select + valid/ready decrement of credit).
// TESTING
//  1 coin 10 then 5 -> dispense 1 cycle after 2nd coin; no chg_valid; credit=0, IDLE.
//  2 coin 10,10 -> dispense; chg_valid chg_coin=01; chg_ready=1 -> IDLE, credit=0.
//  3 single coin 20 (11) -> dispense next cycle; one change coin 01; busy drops after.
//  4 coin 5, cancel; chg_ready low 3 cycles -> chg_valid/chg_coin=01 held; ready -> IDLE.
//  5 coin 5, then TIMEOUT idle cycles -> auto refund chg_coin=01; no dispense.
//  6 coin during CHANGE -> coin_reject, credit unchanged; rst mid-CHANGE -> next cycle all 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending credit controller: FSM states, coin codes and coin values.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam int unsigned COIN_VAL_W = 5;

  // Rupee value of a coin code; the illegal code is worth nothing.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return COIN_VAL_W'(5);
      COIN_10: return COIN_VAL_W'(10);
      COIN_20: return COIN_VAL_W'(20);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Change datapath: next credit after a load or a paid-out coin, and the greedy coin to offer for it.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_credit,
  input  logic                fire,
  input  logic [1:0]          coin,
  output logic [CREDIT_W-1:0] credit_nxt_c,
  output logic [1:0]          coin_nxt_c,
  output logic                empty_c
);

  always_comb begin
    credit_nxt_c = credit;
    if (load) begin
      credit_nxt_c = load_credit;
    end else if (fire) begin
      credit_nxt_c = credit - CREDIT_W'(coin_value(coin));
    end
  end

  // Greedy: Rs10 while at least 10 remains, then Rs5; credit is always a multiple of 5.
  always_comb begin
    coin_nxt_c = COIN_NONE;
    if (credit_nxt_c >= CREDIT_W'(10)) begin
      coin_nxt_c = COIN_10;
    end else if (credit_nxt_c != '0) begin
      coin_nxt_c = COIN_5;
    end
  end

  assign empty_c = (credit_nxt_c == '0);

endmodule

// File: rtl/vend_credit_fsm.sv
// Vending controller: collects coin credit, vends at PRICE, pays change one coin per handshake.
// Optional VEND_SALES_CNT_EN adds a saturating 16-bit sales_cnt output.
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned CREDIT_W = 6,
  parameter int unsigned TIMEOUT  = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                chg_ready,
  output logic                dispense,
  output logic                coin_reject,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic                busy,
`ifdef VEND_SALES_CNT_EN
  output logic [15:0]         sales_cnt,
`endif
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  if ((PRICE % 5) != 0 || PRICE < 5) begin : g_bad_price
    $error("vend_credit_fsm: PRICE must be a multiple of 5 and >= 5");
  end
  if ((2 ** CREDIT_W) <= (PRICE + 15)) begin : g_bad_width
    $error("vend_credit_fsm: CREDIT_W too narrow for PRICE+15");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("vend_credit_fsm: TIMEOUT must be >= 2");
  end

  state_t              state;
  logic [TMO_W-1:0]    tmo_cnt;

  logic                coin_ok_c;
  logic [CREDIT_W-1:0] coin_val_c;
  logic [CREDIT_W-1:0] sum_c;
  logic [CREDIT_W-1:0] price_c;
  logic                tmo_hit_c;
  logic                chg_load_c;
  logic [CREDIT_W-1:0] load_credit_c;
  logic                chg_fire_c;
  logic [CREDIT_W-1:0] credit_nxt_c;
  logic [1:0]          coin_nxt_c;
  logic                empty_c;

  assign price_c    = CREDIT_W'(PRICE);
  assign coin_ok_c  = coin_valid && (coin != COIN_NONE);
  assign coin_val_c = CREDIT_W'(coin_value(coin));
  assign sum_c      = (state == ST_IDLE) ? coin_val_c : credit + coin_val_c;
  assign tmo_hit_c  = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign chg_fire_c = (state == ST_CHANGE) && chg_valid && chg_ready;

  // Entering CHANGE loads either the post-vend remainder or the full credit being refunded.
  assign chg_load_c = (state == ST_VEND) ||
                      ((state == ST_COLLECT) && (cancel || (!coin_ok_c && tmo_hit_c)));
  assign load_credit_c = (state == ST_VEND) ? credit - price_c : credit;

  vend_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change_gen (
    .credit       (credit),
    .load         (chg_load_c),
    .load_credit  (load_credit_c),
    .fire         (chg_fire_c),
    .coin         (chg_coin),
    .credit_nxt_c (credit_nxt_c),
    .coin_nxt_c   (coin_nxt_c),
    .empty_c      (empty_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      credit      <= '0;
      dispense    <= 1'b0;
      coin_reject <= 1'b0;
      chg_valid   <= 1'b0;
      chg_coin    <= COIN_NONE;
      busy        <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coin_ok_c) begin
            credit  <= sum_c;
            tmo_cnt <= '0;
            busy    <= 1'b1;
            if (sum_c >= price_c) begin
              state    <= ST_VEND;
              dispense <= 1'b1;
            end else begin
              state <= ST_COLLECT;
            end
          end else begin
            coin_reject <= coin_valid;
          end
        end
        ST_COLLECT: begin
          if (cancel) begin
            state       <= ST_CHANGE;
            coin_reject <= coin_valid;
            chg_valid   <= 1'b1;
            chg_coin    <= coin_nxt_c;
          end else if (coin_ok_c) begin
            credit  <= sum_c;
            tmo_cnt <= '0;
            if (sum_c >= price_c) begin
              state    <= ST_VEND;
              dispense <= 1'b1;
            end
          end else begin
            coin_reject <= coin_valid;
            if (tmo_hit_c) begin
              state     <= ST_CHANGE;
              chg_valid <= 1'b1;
              chg_coin  <= coin_nxt_c;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end
        ST_VEND: begin
          coin_reject <= coin_valid;
          credit      <= credit_nxt_c;
          if (empty_c) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= ST_CHANGE;
            chg_valid <= 1'b1;
            chg_coin  <= coin_nxt_c;
          end
        end
        ST_CHANGE: begin
          coin_reject <= coin_valid;
          if (chg_fire_c) begin
            credit <= credit_nxt_c;
            if (empty_c) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              chg_valid <= 1'b0;
              chg_coin  <= COIN_NONE;
            end else begin
              chg_coin <= coin_nxt_c;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VEND_SALES_CNT_EN
  // Counts completed sales, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sales_cnt <= '0;
    end else if (dispense && (sales_cnt != 16'hFFFF)) begin
      sales_cnt <= sales_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm (PRICE=15, CREDIT_W=6, TIMEOUT shortened to 12).
module tb_vend_credit_fsm;

  localparam int unsigned PRICE = 15;
  localparam int unsigned CW    = 6;
  localparam int unsigned TMO   = 12;

  logic          clk;
  logic          rst;
  logic          coin_valid;
  logic [1:0]    coin;
  logic          cancel;
  logic          chg_ready;
  logic          dispense;
  logic          coin_reject;
  logic          chg_valid;
  logic [1:0]    chg_coin;
  logic          busy;
  logic [CW-1:0] credit;
`ifdef VEND_SALES_CNT_EN
  logic [15:0]   sales_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [11:0] obs;
  logic [11:0] exp_v;

  // Packed view: {dispense, coin_reject, chg_valid, chg_coin[1:0], busy, credit[5:0]}
  assign obs = {dispense, coin_reject, chg_valid, chg_coin, busy, credit};

  vend_credit_fsm #(
    .PRICE    (PRICE),
    .CREDIT_W (CW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin        (coin),
    .cancel      (cancel),
    .chg_ready   (chg_ready),
    .dispense    (dispense),
    .coin_reject (coin_reject),
    .chg_valid   (chg_valid),
    .chg_coin    (chg_coin),
    .busy        (busy),
`ifdef VEND_SALES_CNT_EN
    .sales_cnt   (sales_cnt),
`endif
    .credit      (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ex(input logic d, input logic r, input logic v,
                                     input logic [1:0] c, input logic b, input int cr);
    return {d, r, v, c, b, 6'(cr)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] c);
    coin_valid = v;
    coin       = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00);
    cancel = 1'b0;
    chg_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset got=%h exp=%h", obs, exp_v); end
    // cancel outside COLLECT is ignored
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL idle_cancel got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_exact();
    drive(1'b1, 2'b10);
    tick();
    exp_v = ex(0, 0, 0, 2'b00, 1, 10);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL exact_c10 got=%h exp=%h", obs, exp_v); end
    drive(1'b1, 2'b01);
    tick();
    exp_v = ex(1, 0, 0, 2'b00, 1, 15);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL exact_vend got=%h exp=%h", obs, exp_v); end
    drive(1'b0, 2'b00);
    tick();
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL exact_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_change_10_10();
    drive(1'b1, 2'b10);
    tick();
    tick();
    exp_v = ex(1, 0, 0, 2'b00, 1, 20);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL c1010_vend got=%h exp=%h", obs, exp_v); end
    drive(1'b0, 2'b00);
    tick();
    exp_v = ex(0, 0, 1, 2'b01, 1, 5);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL c1010_chg got=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL c1010_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_coin20();
    drive(1'b1, 2'b11);
    tick();
    drive(1'b0, 2'b00);
    exp_v = ex(1, 0, 0, 2'b00, 1, 20);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL c20_vend got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = ex(0, 0, 1, 2'b01, 1, 5);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL c20_chg got=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL c20_idle got=%h exp=%h", obs, exp_v); end
  endtask

  // 10 + 20 = 30, change 15 paid as Rs10 then Rs5
  task automatic test_greedy_change();
    drive(1'b1, 2'b10);
    tick();
    drive(1'b1, 2'b11);
    tick();
    drive(1'b0, 2'b00);
    exp_v = ex(1, 0, 0, 2'b00, 1, 30);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL greedy_vend got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = ex(0, 0, 1, 2'b10, 1, 15);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL greedy_c10 got=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick();
    exp_v = ex(0, 0, 1, 2'b01, 1, 5);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL greedy_c5 got=%h exp=%h", obs, exp_v); end
    tick();
    chg_ready = 1'b0;
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL greedy_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_cancel();
    drive(1'b1, 2'b01);
    tick();
    exp_v = ex(0, 0, 0, 2'b00, 1, 5);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL cancel_c5 got=%h exp=%h", obs, exp_v); end
    drive(1'b1, 2'b10);
    cancel = 1'b1;
    tick();
    drive(1'b0, 2'b00);
    cancel = 1'b0;
    exp_v = ex(0, 1, 1, 2'b01, 1, 5);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL cancel_wins got=%h exp=%h", obs, exp_v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = ex(0, 0, 1, 2'b01, 1, 5);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL cancel_hold%0d got=%h exp=%h", i, obs, exp_v); end
    end
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL cancel_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_timeout();
    drive(1'b1, 2'b01);
    tick();
    drive(1'b0, 2'b00);
    for (int i = 0; i < TMO - 2; i++) tick();
    // a legal coin just before expiry restarts the idle count
    drive(1'b1, 2'b01);
    tick();
    drive(1'b0, 2'b00);
    exp_v = ex(0, 0, 0, 2'b00, 1, 10);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL tmo_restart got=%h exp=%h", obs, exp_v); end
    for (int i = 0; i < TMO - 1; i++) tick();
    exp_v = ex(0, 0, 0, 2'b00, 1, 10);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL tmo_early got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = ex(0, 0, 1, 2'b10, 1, 10);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL tmo_refund got=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL tmo_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reject_and_rst();
    drive(1'b1, 2'b00);
    tick();
    drive(1'b0, 2'b00);
    exp_v = ex(0, 1, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL illegal_idle got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reject_pulse got=%h exp=%h", obs, exp_v); end
    drive(1'b1, 2'b11);
    tick();
    drive(1'b1, 2'b01);
    tick();
    exp_v = ex(0, 1, 1, 2'b01, 1, 5);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL vend_reject got=%h exp=%h", obs, exp_v); end
    drive(1'b1, 2'b10);
    tick();
    exp_v = ex(0, 1, 1, 2'b01, 1, 5);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL chg_reject got=%h exp=%h", obs, exp_v); end
    drive(1'b0, 2'b00);
    rst = 1'b1;
    tick();
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rst_mid_chg got=%h exp=%h", obs, exp_v); end
    rst = 1'b0;
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    exp_v = ex(0, 0, 0, 2'b00, 0, 0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rst_no_refund got=%h exp=%h", obs, exp_v); end
  endtask

  initial begin
    rst        = 1'b1;
    coin_valid = 1'b0;
    coin       = 2'b00;
    cancel     = 1'b0;
    chg_ready  = 1'b0;
    test_reset();
    test_exact();
    test_change_10_10();
    test_coin20();
    test_greedy_change();
    test_cancel();
    test_timeout();
    test_reject_and_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
